// File: rtl/map_cell_ctrl.sv
// map_cell_ctrl: owner of the 20x15 playfield cell store (3 bits per cell).
// Two requesters (port 0 = player, port 1 = enemy) share the store through a
// round-robin arbiter, one access per two cycles. A level load streams all
// 300 cells from an external layout ROM with one-cycle read latency.
// Optional build macro: MAP_CTRL_BORDER_LOCK_EN -- when defined, requester
// writes to border cells are dropped (still acknowledged); ROM loads unaffected.
module map_cell_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [4:0]   x0,
  input  logic [4:0]   x1,
  input  logic [3:0]   y0,
  input  logic [3:0]   y1,
  input  logic [2:0]   wdata0,
  input  logic [2:0]   wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [2:0]   rdata,
  input  logic         load_start,
  input  logic [1:0]   load_level,
  output logic [1:0]   rom_level,
  output logic [8:0]   rom_addr,
  input  logic [2:0]   rom_data,
  output logic         busy,
  output logic         load_done,
  output logic [0:899] map
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACK    = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [8:0] LAST_CELL = 9'd299;

  // Linear cell index x + 20*y, kept 9 bits wide.
  function automatic logic [8:0] cell_index(input logic [4:0] x, input logic [3:0] y);
    return {4'd0, x} + (9'd20 * {5'd0, y});
  endfunction

  // First bit position of a cell inside the flattened map vector.
  function automatic logic [9:0] cell_base(input logic [8:0] idx);
    return {1'b0, idx} * 10'd3;
  endfunction

  logic [1:0]   state_q, state_d;
  logic         ptr_q, ptr_d;        // 0: port 0 wins a tie, 1: port 1 wins
  logic         pend_q, pend_d;      // load requested while an ack was in flight
  logic [1:0]   level_q, level_d;
  logic [8:0]   raddr_q, raddr_d;    // address presented to the ROM
  logic [8:0]   waddr_q, waddr_d;    // address whose ROM data arrives this cycle
  logic         dvld_q, dvld_d;      // rom_data is valid for waddr_q
  logic         issued_q, issued_d;  // every ROM address has been presented
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic [2:0]   rdata_q, rdata_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [0:899] map_q, map_d;

  logic         sel1_s;
  logic [4:0]   sx_s;
  logic [3:0]   sy_s;
  logic         swe_s;
  logic [2:0]   swd_s;
  logic         sin_s;
  logic         lock_s;
  logic [9:0]   sbase_s;
  logic [9:0]   wbase_s;

  // Port 1 is served when it is the only requester or holds the priority pointer.
  assign sel1_s  = req1 & (~req0 | ptr_q);
  assign sx_s    = sel1_s ? x1 : x0;
  assign sy_s    = sel1_s ? y1 : y0;
  assign swe_s   = sel1_s ? we1 : we0;
  assign swd_s   = sel1_s ? wdata1 : wdata0;
  assign sin_s   = (sx_s < 5'd20) && (sy_s < 4'd15);
  assign sbase_s = cell_base(cell_index(sx_s, sy_s));
  assign wbase_s = cell_base(waddr_q);

`ifdef MAP_CTRL_BORDER_LOCK_EN
  assign lock_s = (sx_s == 5'd0) || (sx_s == 5'd19) || (sy_s == 4'd0) || (sy_s == 4'd14);
`else
  assign lock_s = 1'b0;
`endif

  // Next-state logic: arbitration, cell access and load sequencing.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    pend_d   = pend_q;
    level_d  = level_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    dvld_d   = dvld_q;
    issued_d = issued_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    map_d    = map_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start || pend_q) begin
          // A fresh load_start brings its own level; a pending load already captured one.
          if (load_start) begin
            level_d = load_level;
          end else begin
            level_d = level_q;
          end
          pend_d   = 1'b0;
          raddr_d  = 9'd0;
          dvld_d   = 1'b0;
          issued_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_LOAD;
        end else if (req0 || req1) begin
          ptr_d  = ~sel1_s;
          ack0_d = ~sel1_s;
          ack1_d = sel1_s;
          if (swe_s) begin
            if (sin_s && !lock_s) begin
              map_d[sbase_s +: 3] = swd_s;
            end else begin
              map_d = map_q;
            end
          end else begin
            if (sin_s) begin
              rdata_d = map_q[sbase_s +: 3];
            end else begin
              rdata_d = 3'd0;
            end
          end
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        // Requests seen here are left for the next idle cycle; a load is remembered.
        if (load_start) begin
          pend_d  = 1'b1;
          level_d = load_level;
        end else begin
          pend_d  = pend_q;
        end
        state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (dvld_q) begin
          map_d[wbase_s +: 3] = rom_data;
        end else begin
          map_d = map_q;
        end
        if (!issued_q) begin
          waddr_d = raddr_q;
          dvld_d  = 1'b1;
          if (raddr_q == LAST_CELL) begin
            issued_d = 1'b1;
          end else begin
            raddr_d = raddr_q + 9'd1;
          end
        end else begin
          // This cycle wrote the final cell; leave the load.
          dvld_d   = 1'b0;
          issued_d = 1'b0;
          raddr_d  = 9'd0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      pend_q   <= 1'b0;
      level_q  <= 2'd0;
      raddr_q  <= 9'd0;
      waddr_q  <= 9'd0;
      dvld_q   <= 1'b0;
      issued_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata_q  <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      map_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      level_q  <= level_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      dvld_q   <= dvld_d;
      issued_q <= issued_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      map_q    <= map_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign rom_level = level_q;
  assign rom_addr  = raddr_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign map       = map_q;

endmodule

// File: tb/tb_map_cell_ctrl.sv
// tb_map_cell_ctrl: scoreboard bench for map_cell_ctrl. Stimulus pushes the
// expected ack (port, read value) into a queue; a monitor pops on every ack.
module tb_map_cell_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [4:0]   x0, x1;
  logic [3:0]   y0, y1;
  logic [2:0]   wdata0, wdata1;
  logic         ack0, ack1;
  logic [2:0]   rdata;
  logic         load_start;
  logic [1:0]   load_level;
  logic [1:0]   rom_level;
  logic [8:0]   rom_addr;
  logic [2:0]   rom_data;
  logic         busy, load_done;
  logic [0:899] map;

  map_cell_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .load_start(load_start), .load_level(load_level),
    .rom_level(rom_level), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .load_done(load_done), .map(map)
  );

  always #5 clk = ~clk;

  // Layout ROM model: one-cycle latency, content = address mod 3.
  always @(posedge clk) rom_data <= 3'(rom_addr % 9'd3);

  typedef struct { int port; bit rd; int exp; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cells[300];
  int ptr_m = 0;          // port that wins the next tie
  int cyc = 0;
  int done_cnt = 0;
  int last_ack_cyc = -10;

  function automatic void check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  task automatic compare_map(input string name);
    logic [0:899] em;
    int first;
    for (int i = 0; i < 300; i++) em[3*i +: 3] = 3'(cells[i]);
    total++;
    if (map !== em) begin
      bad++;
      first = -1;
      for (int i = 0; i < 300; i++) if (first < 0 && map[3*i +: 3] !== em[3*i +: 3]) first = i;
      $display("FAIL %s first bad cell %0d actual=%0d required=%0d", name, first,
               map[3*first +: 3], em[3*first +: 3]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every ack pops one expected entry.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (load_done) done_cnt++;
    if (ack0 || ack1) begin
      check("ack_exclusive", longint'(ack0 && ack1), 0);
      check("ack_spacing", longint'((cyc - last_ack_cyc) >= 2), 1);
      last_ack_cyc = cyc;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack actual=ack%0d required=none", ack1 ? 1 : 0);
      end else begin
        e = sb.pop_front();
        check("ack_port", ack1 ? 1 : 0, e.port);
        if (e.rd) check("rdata", rdata, e.exp);
      end
    end
  end

  // Reference behaviour of one requester access; returns the expected ack entry.
  function automatic exp_t model_access(input int port, input bit we, input int x, input int y, input int wd);
    exp_t e;
    bit inr, lock;
    inr  = (x < 20) && (y < 15);
    lock = 1'b0;
`ifdef MAP_CTRL_BORDER_LOCK_EN
    lock = (x == 0) || (x == 19) || (y == 0) || (y == 14);
`endif
    e.port = port;
    e.rd   = !we;
    e.exp  = 0;
    if (we) begin
      if (inr && !lock) cells[x + 20*y] = wd;
    end else begin
      e.exp = inr ? cells[x + 20*y] : 0;
    end
    return e;
  endfunction

  task automatic drive(input int port, input bit we, input int x, input int y, input int wd);
    if (port == 0) begin
      we0 = we; x0 = 5'(x); y0 = 4'(y); wdata0 = 3'(wd); req0 = 1'b1;
    end else begin
      we1 = we; x1 = 5'(x); y1 = 4'(y); wdata1 = 3'(wd); req1 = 1'b1;
    end
  endtask

  // Single access issued in an idle cycle; the ack must follow one cycle later.
  task automatic access(input int port, input bit we, input int x, input int y, input int wd);
    sb.push_back(model_access(port, we, x, y, wd));
    ptr_m = 1 - port;
    drive(port, we, x, y, wd);
    @(posedge clk); #1;
    check("ack_latency", port ? ack1 : ack0, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input int limit, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s actual=no_ack required=ack within %0d cycles", name, limit);
    end
  endtask

  // Both ports held writing distinct cells; acks must alternate every 2 cycles.
  task automatic contention(input int n);
    int p, prev;
    for (int i = 0; i < n; i++) begin
      p = (ptr_m + i) % 2;
      sb.push_back(model_access(p, 1'b1, p ? 9 : 4, p ? 9 : 4, p ? 2 : 1));
    end
    ptr_m = 1 - ((ptr_m + n - 1) % 2);
    drive(0, 1'b1, 4, 4, 1);
    drive(1, 1'b1, 9, 9, 2);
    prev = 0;
    for (int i = 0; i < n; i++) begin
      wait_ack(4, "rr_ack_timeout");
      if (i > 0) check("rr_gap", cyc - prev, 2);
      prev = cyc;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack0"}, ack0, 0);
    check({tag, "_ack1"}, ack1, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_rom_level"}, rom_level, 0);
    compare_map({tag, "_map"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done0;
    bit found;
    exp_t e;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    x0 = 5'd0; x1 = 5'd0; y0 = 4'd0; y1 = 4'd0; wdata0 = 3'd0; wdata1 = 3'd0;
    load_start = 1'b0; load_level = 2'd0;
    for (int i = 0; i < 300; i++) cells[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write then read on port 0.
    access(0, 1'b1, 3, 2, 1);
    access(0, 1'b0, 3, 2, 0);
    check("map_bits_129_131", map[129:131], 1);

    // Out-of-range accesses are acked and have no effect.
    access(0, 1'b1, 20, 0, 3);
    access(1, 1'b0, 5, 15, 0);
    compare_map("out_of_range_map");

    // Border cell write (effect depends on the lock build option).
    access(1, 1'b1, 0, 7, 1);
    compare_map("border_map");
    access(0, 1'b0, 0, 7, 0);

    // Read-after-write by the other port.
    access(0, 1'b1, 8, 8, 2);
    access(1, 1'b0, 8, 8, 0);

    // Random single accesses.
    for (int i = 0; i < 40; i++)
      access($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 21),
             $urandom_range(0, 15), $urandom_range(0, 7));
    compare_map("random_map");

    contention(6);
    compare_map("contention_map");

    // Level load with port 0 request held throughout.
    done0 = done_cnt;
    load_level = 2'd2;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("load_busy_start", busy, 1);
    check("load_rom_level", rom_level, 2);
    check("load_rom_addr0", rom_addr, 0);
    for (int k = 0; k < 300; k++) cells[k] = k % 3;
    sb.push_back(model_access(0, 1'b0, 3, 2, 0));
    ptr_m = 1;
    drive(0, 1'b0, 3, 2, 0);
    n = 1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
      n++;
      if (n == 151) check("load_rom_addr150", rom_addr, 150);
    end
    check("busy_cycles", n, 301);
    check("load_done_at_busy_fall", load_done, 1);
    @(posedge clk); #1;
    check("ack0_after_load", ack0, 1);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("load_done_count", done_cnt - done0, 1);
    check("cell299", map[897:899], 2);
    compare_map("load_map");

    // load_start during an ACK cycle is held pending until the next idle cycle.
    sb.push_back(model_access(1, 1'b0, 3, 2, 0));
    ptr_m = 0;
    drive(1, 1'b0, 3, 2, 0);
    @(posedge clk); #1;
    check("pend_ack1", ack1, 1);
    req1 = 1'b0;
    load_level = 2'd1;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("pend_idle_not_busy", busy, 0);
    @(posedge clk); #1;
    check("pend_load_busy", busy, 1);
    check("pend_rom_level", rom_level, 1);

    // Reset in the middle of the load.
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rom_addr == 9'd150) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reach_rom_addr150", found, 1);
    done0 = done_cnt;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 300; i++) cells[i] = 0;
    ptr_m = 0;
    check_reset_outputs("midload_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("no_load_done_after_reset", done_cnt - done0, 0);
    check("busy_after_reset", busy, 0);

    // Pointer starts at port 0 after reset.
    contention(4);
    compare_map("final_map");
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
